// File: rtl/sram_sdp_be_pkg.sv
// Shared types and default sizes for the simple-dual-port byte-enable SRAM.
//   rdw_mode_e   : same-address read-during-write result selection
//   sram_state_e : states of the post-reset clear sequencer
//   SRAM_DEF_*   : default geometry shared with the FIFO storage blocks
package sram_sdp_be_pkg;

    typedef enum logic {
        RDW_READ_FIRST,
        RDW_WRITE_FIRST
    } rdw_mode_e;

    typedef enum logic {
        SRAM_CLEAR,
        SRAM_READY
    } sram_state_e;

    localparam int SRAM_DEF_DATA_WIDTH = 32;
    localparam int SRAM_DEF_DEPTH      = 16;
    localparam int SRAM_DEF_ADDR_WIDTH = $clog2(SRAM_DEF_DEPTH);

endpackage

// File: rtl/sram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once, asking the array to
// write zero there, then parks in READY until the next reset.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   init_busy_o  : high while the clear walk is in progress
//   clr_en_o     : array write strobe for the clear walk
//   clr_addr_o   : address being cleared this cycle
module sram_clear_fsm
    import sram_sdp_be_pkg::*;
#(
    parameter int DEPTH          = SRAM_DEF_DEPTH,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy_o,
    output logic                  clr_en_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    sram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? SRAM_CLEAR : SRAM_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_en_o    = 1'b0;
        init_busy_o = 1'b0;
        case (state_q)
            SRAM_CLEAR: begin
                clr_en_o    = 1'b1;
                init_busy_o = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = SRAM_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = SRAM_READY;
            end
        endcase
    end

    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/sram_sdp_be.sv
// Simple-dual-port SRAM with per-byte write enables, a 1- or 2-cycle read
// pipeline and selectable same-address read-during-write behaviour.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (read pipeline only;
//                 the array itself is zeroed by the clear sequencer)
//   init_busy_o : clear sequence running, port traffic ignored
//   wr_*_i      : write request, address, data, byte enables
//   rd_en_i     : read request, rd_addr_i sampled on the same edge
//   rd_data_o   : read data, holds its value between valid pulses
//   rd_valid_o  : one pulse per accepted read
module sram_sdp_be
    import sram_sdp_be_pkg::*;
#(
    parameter int        DATA_WIDTH     = SRAM_DEF_DATA_WIDTH,
    parameter int        DEPTH          = SRAM_DEF_DEPTH,
    parameter int        ADDR_WIDTH     = $clog2(DEPTH),
    parameter int        READ_LATENCY   = 1,
    parameter rdw_mode_e RDW_MODE       = RDW_READ_FIRST,
    parameter bit        CLEAR_ON_RESET = 1'b1,
    localparam int       NUM_BYTES      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [NUM_BYTES-1:0]  wr_be_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    function automatic logic [DATA_WIDTH-1:0] be_mask(input logic [NUM_BYTES-1:0] be);
        for (int b = 0; b < NUM_BYTES; b++) begin
            be_mask[8*b +: 8] = {8{be[b]}};
        end
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_ok, rd_ok, rd_in_range;
    logic [DATA_WIDTH-1:0] wr_word, rd_word;

    sram_clear_fsm #(
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk         (clk),
        .rst         (rst),
        .init_busy_o (init_busy_o),
        .clr_en_o    (clr_en),
        .clr_addr_o  (clr_addr)
    );

    // Out-of-range addresses exist only when DEPTH is not a power of two.
    assign wr_ok       = !init_busy_o && wr_en_i && ({1'b0, wr_addr_i} < DEPTH_L);
    assign rd_ok       = !init_busy_o && rd_en_i;
    assign rd_in_range = {1'b0, rd_addr_i} < DEPTH_L;

    always_comb begin
        wr_word = (mem_q[wr_addr_i] & ~be_mask(wr_be_i)) | (wr_data_i & be_mask(wr_be_i));
        rd_word = mem_q[rd_addr_i];
        if (!rd_in_range) begin
            rd_word = '0;
        end else if (RDW_MODE == RDW_WRITE_FIRST && wr_ok && wr_addr_i == rd_addr_i) begin
            rd_word = wr_word;
        end
    end

    // The clear walk and port writes never coincide: ports are gated by init_busy_o.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr_i] <= wr_word;
        end
    end

    // ---- stage p1: array read registered ----
    logic                  rd_vld_p1_q;
    logic [DATA_WIDTH-1:0] rd_data_p1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_p1_q  <= 1'b0;
            rd_data_p1_q <= '0;
        end else begin
            rd_vld_p1_q <= rd_ok;
            if (rd_ok) begin
                rd_data_p1_q <= rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            // ---- stage p2: output register for the two-cycle read ----
            logic                  rd_vld_p2_q;
            logic [DATA_WIDTH-1:0] rd_data_p2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_vld_p2_q  <= 1'b0;
                    rd_data_p2_q <= '0;
                end else begin
                    rd_vld_p2_q <= rd_vld_p1_q;
                    if (rd_vld_p1_q) begin
                        rd_data_p2_q <= rd_data_p1_q;
                    end
                end
            end

            assign rd_valid_o = rd_vld_p2_q;
            assign rd_data_o  = rd_data_p2_q;
        end else begin : g_lat1
            assign rd_valid_o = rd_vld_p1_q;
            assign rd_data_o  = rd_data_p1_q;
        end
    endgenerate

endmodule

// File: tb/tb_sram_sdp_be.sv
// Bench for sram_sdp_be: four instances share one stimulus stream
//   k=0 latency 1, read-first, depth 16
//   k=1 latency 1, write-first, depth 16
//   k=2 latency 2, read-first, depth 16
//   k=3 latency 1, read-first, depth 12
// A word-level memory model per instance predicts every output.
module tb_sram_sdp_be;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [31:0] rdat [4];
    logic        rvld [4];
    logic        busy [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_sdp_be #(.READ_LATENCY(1), .RDW_MODE(sram_sdp_be_pkg::RDW_READ_FIRST), .DEPTH(16), .CLEAR_ON_RESET(1)) u_rf (
        .clk(clk), .rst(rst), .init_busy_o(busy[0]), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdat[0]), .rd_valid_o(rvld[0]));
    sram_sdp_be #(.READ_LATENCY(1), .RDW_MODE(sram_sdp_be_pkg::RDW_WRITE_FIRST), .DEPTH(16), .CLEAR_ON_RESET(1)) u_wf (
        .clk(clk), .rst(rst), .init_busy_o(busy[1]), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdat[1]), .rd_valid_o(rvld[1]));
    sram_sdp_be #(.READ_LATENCY(2), .RDW_MODE(sram_sdp_be_pkg::RDW_READ_FIRST), .DEPTH(16), .CLEAR_ON_RESET(1)) u_l2 (
        .clk(clk), .rst(rst), .init_busy_o(busy[2]), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdat[2]), .rd_valid_o(rvld[2]));
    sram_sdp_be #(.READ_LATENCY(1), .RDW_MODE(sram_sdp_be_pkg::RDW_READ_FIRST), .DEPTH(12), .CLEAR_ON_RESET(1)) u_d12 (
        .clk(clk), .rst(rst), .init_busy_o(busy[3]), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdat[3]), .rd_valid_o(rvld[3]));

    // Reference model
    int          lat [4] = '{1, 1, 2, 1};
    bit          wf  [4] = '{0, 1, 0, 0};
    int          dep [4] = '{16, 16, 16, 12};
    logic [31:0] mm  [4][16];
    int          cnt [4];
    bit          pv  [4];
    logic [31:0] pd  [4];
    bit          ev  [4];
    logic [31:0] ed  [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            cnt[k] = 0; pv[k] = 0; pd[k] = '0; ev[k] = 0; ed[k] = '0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] merged, nd;
        bit nv, wr_in, rd_in;
        for (int k = 0; k < 4; k++) begin
            nv = 0; nd = '0;
            if (cnt[k] < dep[k]) begin
                mm[k][cnt[k]] = '0;
                cnt[k]++;
            end else begin
                wr_in  = wr_en && (int'(wr_addr) < dep[k]);
                rd_in  = int'(rd_addr) < dep[k];
                merged = mm[k][wr_addr];
                for (int b = 0; b < 4; b++)
                    if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
                if (rd_en) begin
                    nv = 1;
                    if (!rd_in) nd = '0;
                    else if (wf[k] && wr_in && wr_addr == rd_addr) nd = merged;
                    else nd = mm[k][rd_addr];
                end
                if (wr_in) mm[k][wr_addr] = merged;
            end
            if (lat[k] == 1) begin
                ev[k] = nv;
                if (nv) ed[k] = nd;
            end else begin
                ev[k] = pv[k];
                if (pv[k]) ed[k] = pd[k];
                pv[k] = nv;
                if (nv) pd[k] = nd;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    endtask

    task automatic set_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic set_rd(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
    endtask

    task automatic test_reset();
        int nb [4];
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdat[k] !== 32'h0 || rvld[k] !== 1'b0 || busy[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state[%0d]: data=%h valid=%b busy=%b, required 0/0/1", k, rdat[k], rvld[k], busy[k]);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) nb[k] = (busy[k] === 1'b1) ? 1 : 0;
        repeat (20) begin
            cyc();
            for (int k = 0; k < 4; k++) if (busy[k] === 1'b1) nb[k]++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (nb[k] != dep[k] || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL clear_duration[%0d]: busy cycles=%0d end=%b, required %0d and 0", k, nb[k], busy[k], dep[k]);
            end
        end
    endtask

    task automatic test_clear_zero();
        for (int i = 0; i < 16; i++) begin
            set_rd(4'(i));
            cyc();
            checks++;
            if (rvld[0] !== 1'b1 || rdat[0] !== 32'h0) begin
                errors++;
                $display("FAIL clear_zero addr %0d: valid=%b data=%h, required 1 and 00000000", i, rvld[0], rdat[0]);
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_byte_enables();
        set_wr(4'd3, 32'hAABBCCDD, 4'hF); cyc();
        set_wr(4'd3, 32'h11223344, 4'b0101); cyc();
        idle(); set_rd(4'd3);
        checks++;
        if (rvld[0] !== 1'b0) begin
            errors++;
            $display("FAIL be_no_early_valid: valid=%b, required 0", rvld[0]);
        end
        cyc();
        idle();
        checks++;
        if (rvld[0] !== 1'b1 || rdat[0] !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL byte_enable: valid=%b data=%h, required 1 and aa22cc44", rvld[0], rdat[0]);
        end
        cyc();
        checks++;
        if (rvld[0] !== 1'b0 || rdat[0] !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL read_hold: valid=%b data=%h, required 0 and aa22cc44", rvld[0], rdat[0]);
        end
    endtask

    task automatic test_rdw();
        set_wr(4'd5, 32'hDEADBEEF, 4'hF); set_rd(4'd5);
        cyc();
        checks++;
        if (rdat[0] !== 32'h0 || rvld[0] !== 1'b1) begin
            errors++;
            $display("FAIL rdw_read_first: data=%h valid=%b, required 00000000 and 1", rdat[0], rvld[0]);
        end
        checks++;
        if (rdat[1] !== 32'hDEADBEEF || rvld[1] !== 1'b1) begin
            errors++;
            $display("FAIL rdw_write_first: data=%h valid=%b, required deadbeef and 1", rdat[1], rvld[1]);
        end
        wr_en = 1'b0;
        cyc();
        checks++;
        if (rdat[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdw_after_write: data=%h, required deadbeef", rdat[0]);
        end
        idle();
        cyc();
    endtask

    task automatic test_lat2_stream();
        for (int i = 0; i < 4; i++) begin
            set_wr(4'(i), 32'h10 + 32'(i), 4'hF);
            cyc();
        end
        idle();
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) set_rd(4'(c - 1)); else rd_en = 1'b0;
            cyc();
            checks++;
            if (rvld[2] !== (c >= 2 && c <= 5)) begin
                errors++;
                $display("FAIL lat2_valid cycle %0d: valid=%b, required %b", c, rvld[2], (c >= 2 && c <= 5));
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (rdat[2] !== 32'h10 + 32'(c - 2)) begin
                    errors++;
                    $display("FAIL lat2_data cycle %0d: data=%h, required %h", c, rdat[2], 32'h10 + 32'(c - 2));
                end
            end
        end
    endtask

    task automatic test_ignore_during_clear();
        int seen = 0;
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 2) begin set_wr(4'd0, 32'h55, 4'hF); set_rd(4'd0); end
            else idle();
            cyc();
            if (rvld[0] !== 1'b0 || rdat[0] !== 32'h0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL clear_ignores_ports: %0d bad cycles, required 0", seen);
        end
        set_rd(4'd0);
        cyc();
        idle();
        checks++;
        if (rvld[0] !== 1'b1 || rdat[0] !== 32'h0) begin
            errors++;
            $display("FAIL clear_write_dropped: valid=%b data=%h, required 1 and 00000000", rvld[0], rdat[0]);
        end
        cyc();
    endtask

    task automatic test_reset_midop();
        int nb = 0, seen = 0;
        set_wr(4'd1, 32'h12345678, 4'hF); cyc();
        idle(); set_rd(4'd1); cyc();
        idle();
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (rvld[2] !== 1'b0 || rdat[2] !== 32'h0 || rdat[0] !== 32'h0 || busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_midop_immediate: valid=%b data=%h data0=%h busy=%b, required 0/0/0/1",
                     rvld[2], rdat[2], rdat[0], busy[2]);
        end
        repeat (2) begin
            @(posedge clk); #1;
            if (rvld[2] !== 1'b0 || rdat[2] !== 32'h0) seen++;
        end
        rst = 1'b0;
        if (busy[2] === 1'b1) nb++;
        repeat (20) begin
            cyc();
            if (busy[2] === 1'b1) nb++;
            if (rvld[2] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_midop_no_valid: %0d bad cycles, required 0", seen);
        end
        checks++;
        if (nb != 16) begin
            errors++;
            $display("FAIL reset_midop_clear: busy cycles=%0d, required 16", nb);
        end
    endtask

    task automatic test_out_of_range();
        set_wr(4'd13, 32'hCAFEF00D, 4'hF); cyc();
        idle(); set_rd(4'd13); cyc();
        idle();
        checks++;
        if (rvld[3] !== 1'b1 || rdat[3] !== 32'h0) begin
            errors++;
            $display("FAIL oor_read_d12: valid=%b data=%h, required 1 and 00000000", rvld[3], rdat[3]);
        end
        checks++;
        if (rvld[0] !== 1'b1 || rdat[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL inrange_read_d16: valid=%b data=%h, required 1 and cafef00d", rvld[0], rdat[0]);
        end
        cyc();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rd_en   = ($urandom_range(0, 3) != 0);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            cyc();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rvld[k] !== ev[k] || rdat[k] !== ed[k] || busy[k] !== (cnt[k] < dep[k])) begin
                    errors++;
                    $display("FAIL random[%0d] step %0d: valid=%b data=%h busy=%b, required %b %h %b",
                             k, n, rvld[k], rdat[k], busy[k], ev[k], ed[k], (cnt[k] < dep[k]));
                end
            end
        end
        idle();
    endtask

    initial begin
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 16; a++) mm[k][a] = '0;
        test_reset();
        test_clear_zero();
        test_byte_enables();
        test_rdw();
        test_lat2_stream();
        test_ignore_during_clear();
        test_reset_midop();
        test_out_of_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
